// File: rtl/io_output_buffer_if.sv
// LSU-side bus into the memory-mapped output buffer.
// master: LSU drives addr/data/strobe/mask; slave: buffer returns ld_data.
interface io_output_buffer_if;
    logic [31:0] i_lsu_addr;
    logic [31:0] i_st_data;
    logic        i_lsu_wren;
    logic [3:0]  i_bmask;
    logic [31:0] o_ld_data;

    modport master (
        output i_lsu_addr,
        output i_st_data,
        output i_lsu_wren,
        output i_bmask,
        input  o_ld_data
    );

    modport slave (
        input  i_lsu_addr,
        input  i_st_data,
        input  i_lsu_wren,
        input  i_bmask,
        output o_ld_data
    );
endinterface

// File: rtl/io_output_buffer.sv
// Memory-mapped output registers (LEDR, LEDG, HEXLO, HEXHI, LCD) at 0x1000_xxxx.
// Ports: i_clk, i_rst (sync, active-high), lsu bus (slave), LED/HEX/LCD outputs, o_st_cnt.
module io_output_buffer (
    input  logic                  i_clk,
    input  logic                  i_rst,
    io_output_buffer_if.slave     lsu,
    output logic [31:0]           o_io_ledr,
    output logic [31:0]           o_io_ledg,
    output logic [6:0]            o_io_hex0,
    output logic [6:0]            o_io_hex1,
    output logic [6:0]            o_io_hex2,
    output logic [6:0]            o_io_hex3,
    output logic [6:0]            o_io_hex4,
    output logic [6:0]            o_io_hex5,
    output logic [6:0]            o_io_hex6,
    output logic [6:0]            o_io_hex7,
    output logic [31:0]           o_io_lcd,
    output logic [15:0]           o_st_cnt
);
    logic [31:0] ledr_q;
    logic [31:0] ledg_q;
    logic [31:0] hexlo_q;
    logic [31:0] hexhi_q;
    logic [31:0] lcd_q;
    logic [15:0] cnt_q;

    logic        hit;
    logic [3:0]  sel;
    logic        mapped;
    logic        accept;
    logic [11:0] unused_offset;

    // Offset bits alias every location within a register.
    assign unused_offset = lsu.i_lsu_addr[11:0];

    assign hit    = (lsu.i_lsu_addr[31:16] == 16'h1000);
    assign sel    = lsu.i_lsu_addr[15:12];
    assign mapped = hit && (sel <= 4'd4);
    assign accept = lsu.i_lsu_wren && mapped;

    function automatic logic [31:0] merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  mask
    );
        logic [31:0] r;
        r = old_v;
        for (int n = 0; n < 4; n++) begin
            if (mask[n]) r[n*8 +: 8] = new_v[n*8 +: 8];
        end
        return r;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ledr_q  <= '0;
            ledg_q  <= '0;
            hexlo_q <= '0;
            hexhi_q <= '0;
            lcd_q   <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            case (sel)
                4'd0: ledr_q  <= merge(ledr_q,  lsu.i_st_data, lsu.i_bmask);
                4'd1: ledg_q  <= merge(ledg_q,  lsu.i_st_data, lsu.i_bmask);
                4'd2: hexlo_q <= merge(hexlo_q, lsu.i_st_data, lsu.i_bmask);
                4'd3: hexhi_q <= merge(hexhi_q, lsu.i_st_data, lsu.i_bmask);
                4'd4: lcd_q   <= merge(lcd_q,   lsu.i_st_data, lsu.i_bmask);
                default: ;
            endcase
            // A zero mask still counts; the counter wraps silently.
            cnt_q <= cnt_q + 16'd1;
        end
    end

    // Readback shows the current register, never the in-flight store.
    always_comb begin
        lsu.o_ld_data = 32'h0;
        if (hit) begin
            case (sel)
                4'd0: lsu.o_ld_data = ledr_q;
                4'd1: lsu.o_ld_data = ledg_q;
                4'd2: lsu.o_ld_data = hexlo_q;
                4'd3: lsu.o_ld_data = hexhi_q;
                4'd4: lsu.o_ld_data = lcd_q;
                default: lsu.o_ld_data = 32'h0;
            endcase
        end
    end

    assign o_io_ledr = ledr_q;
    assign o_io_ledg = ledg_q;
    assign o_io_lcd  = lcd_q;
    assign o_st_cnt  = cnt_q;

    // Bit 7 of each HEX byte is kept for readback but not driven out.
    assign o_io_hex0 = hexlo_q[6:0];
    assign o_io_hex1 = hexlo_q[14:8];
    assign o_io_hex2 = hexlo_q[22:16];
    assign o_io_hex3 = hexlo_q[30:24];
    assign o_io_hex4 = hexhi_q[6:0];
    assign o_io_hex5 = hexhi_q[14:8];
    assign o_io_hex6 = hexhi_q[22:16];
    assign o_io_hex7 = hexhi_q[30:24];
endmodule

// File: tb/tb_io_output_buffer.sv
// Directed self-checking bench for io_output_buffer.
// Drives the LSU bus through the interface, checks registered outputs and readback.
module tb_io_output_buffer;
    logic        clk;
    logic        rst;
    logic [31:0] ledr;
    logic [31:0] ledg;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic [31:0] lcd;
    logic [15:0] cnt;

    int n_checks;
    int n_fail;

    io_output_buffer_if bus ();

    io_output_buffer dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .lsu       (bus.slave),
        .o_io_ledr (ledr),
        .o_io_ledg (ledg),
        .o_io_hex0 (hex0),
        .o_io_hex1 (hex1),
        .o_io_hex2 (hex2),
        .o_io_hex3 (hex3),
        .o_io_hex4 (hex4),
        .o_io_hex5 (hex5),
        .o_io_hex6 (hex6),
        .o_io_hex7 (hex7),
        .o_io_lcd  (lcd),
        .o_st_cnt  (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_store(
        input logic [31:0] a,
        input logic [31:0] d,
        input logic [3:0]  m
    );
        @(negedge clk);
        bus.i_lsu_addr = a;
        bus.i_st_data  = d;
        bus.i_bmask    = m;
        bus.i_lsu_wren = 1'b1;
        @(posedge clk);
        #1;
        bus.i_lsu_wren = 1'b0;
    endtask

    task automatic set_addr(input logic [31:0] a);
        bus.i_lsu_addr = a;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (ledr !== 32'h0 || ledg !== 32'h0 || lcd !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_words ledr=%h ledg=%h lcd=%h want 0", ledr, ledg, lcd);
        end
        n_checks++;
        if ({hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0} !== 56'h0) begin
            n_fail++;
            $display("FAIL reset_hex got %h want 0",
                     {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0});
        end
        n_checks++;
        if (cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_cnt got %h want 0", cnt);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_ledr_word;
        do_store(32'h1000_0000, 32'h0000_0001, 4'hF);
        n_checks++;
        if (ledr !== 32'h1) begin
            n_fail++;
            $display("FAIL ledr_word got %h want 00000001", ledr);
        end
        n_checks++;
        if (cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL ledr_cnt got %0d want 1", cnt);
        end
        set_addr(32'h1000_0000);
        n_checks++;
        if (bus.o_ld_data !== 32'h1) begin
            n_fail++;
            $display("FAIL ledr_ld got %h want 00000001", bus.o_ld_data);
        end
    endtask

    task automatic test_byte_merge;
        do_store(32'h1000_2000, 32'hFFFF_FFFF, 4'hF);
        do_store(32'h1000_2ABC, 32'h0012_0000, 4'b0100);
        set_addr(32'h1000_2ABC);
        n_checks++;
        if (bus.o_ld_data !== 32'hFF12_FFFF) begin
            n_fail++;
            $display("FAIL merge_ld got %h want ff12ffff", bus.o_ld_data);
        end
        n_checks++;
        if (hex2 !== 7'h12) begin
            n_fail++;
            $display("FAIL merge_hex2 got %h want 12", hex2);
        end
        n_checks++;
        if (hex0 !== 7'h7F || hex1 !== 7'h7F || hex3 !== 7'h7F) begin
            n_fail++;
            $display("FAIL merge_keep got %h %h %h want 7f", hex0, hex1, hex3);
        end
        n_checks++;
        if (cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL merge_cnt got %0d want 3", cnt);
        end
    endtask

    task automatic test_hexhi;
        do_store(32'h1000_3FFC, 32'h8180_7F01, 4'b1010);
        set_addr(32'h1000_3000);
        n_checks++;
        if (bus.o_ld_data !== 32'h8100_7F00) begin
            n_fail++;
            $display("FAIL hexhi_ld got %h want 81007f00", bus.o_ld_data);
        end
        n_checks++;
        if (hex7 !== 7'h01 || hex6 !== 7'h00 || hex5 !== 7'h7F || hex4 !== 7'h00) begin
            n_fail++;
            $display("FAIL hexhi_digits got %h %h %h %h want 01 00 7f 00",
                     hex7, hex6, hex5, hex4);
        end
    endtask

    task automatic test_unmapped;
        do_store(32'h1000_7000, 32'hFFFF_FFFF, 4'hF);
        do_store(32'h2000_0000, 32'hFFFF_FFFF, 4'hF);
        n_checks++;
        if (cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL unmapped_cnt got %0d want 4", cnt);
        end
        n_checks++;
        if (ledr !== 32'h1 || lcd !== 32'h0 || ledg !== 32'h0) begin
            n_fail++;
            $display("FAIL unmapped_regs ledr=%h ledg=%h lcd=%h", ledr, ledg, lcd);
        end
        set_addr(32'h1000_7000);
        n_checks++;
        if (bus.o_ld_data !== 32'h0) begin
            n_fail++;
            $display("FAIL unmapped_ld got %h want 0", bus.o_ld_data);
        end
        set_addr(32'h2000_0000);
        n_checks++;
        if (bus.o_ld_data !== 32'h0) begin
            n_fail++;
            $display("FAIL outregion_ld got %h want 0", bus.o_ld_data);
        end
    endtask

    task automatic test_same_cycle;
        do_store(32'h1000_1000, 32'hA5A5_A5A5, 4'hF);
        @(negedge clk);
        bus.i_lsu_addr = 32'h1000_1000;
        bus.i_st_data  = 32'h5A5A_5A5A;
        bus.i_bmask    = 4'hF;
        bus.i_lsu_wren = 1'b1;
        #1;
        n_checks++;
        if (bus.o_ld_data !== 32'hA5A5_A5A5) begin
            n_fail++;
            $display("FAIL same_cycle_pre got %h want a5a5a5a5", bus.o_ld_data);
        end
        @(posedge clk);
        #1;
        bus.i_lsu_wren = 1'b0;
        #1;
        n_checks++;
        if (bus.o_ld_data !== 32'h5A5A_5A5A || ledg !== 32'h5A5A_5A5A) begin
            n_fail++;
            $display("FAIL same_cycle_post ld=%h ledg=%h want 5a5a5a5a",
                     bus.o_ld_data, ledg);
        end
    endtask

    task automatic test_zero_mask;
        do_store(32'h1000_4000, 32'hFFFF_FFFF, 4'h0);
        n_checks++;
        if (lcd !== 32'h0 || cnt !== 16'd7) begin
            n_fail++;
            $display("FAIL zero_mask lcd=%h cnt=%0d want 0 and 7", lcd, cnt);
        end
    endtask

    task automatic test_reset_priority;
        @(negedge clk);
        rst = 1'b1;
        bus.i_lsu_addr = 32'h1000_4000;
        bus.i_st_data  = 32'hDEAD_BEEF;
        bus.i_bmask    = 4'hF;
        bus.i_lsu_wren = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (lcd !== 32'h0 || cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_prio lcd=%h cnt=%0d want 0", lcd, cnt);
        end
        n_checks++;
        if (ledr !== 32'h0 || ledg !== 32'h0 || hex2 !== 7'h0 || hex5 !== 7'h0) begin
            n_fail++;
            $display("FAIL rst_residual ledr=%h ledg=%h hex2=%h hex5=%h",
                     ledr, ledg, hex2, hex5);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.i_st_data = 32'h1234_5678;
        @(posedge clk);
        #1;
        bus.i_lsu_wren = 1'b0;
        n_checks++;
        if (lcd !== 32'h1234_5678 || cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL first_after_rst lcd=%h cnt=%0d want 12345678 and 1", lcd, cnt);
        end
    endtask

    task automatic test_counter_wrap;
        @(negedge clk);
        rst = 1'b1;
        bus.i_lsu_wren = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus.i_st_data = 32'hFFFF_FFFF;
        bus.i_bmask   = 4'h0;
        for (int i = 0; i < 65535; i++) begin
            @(negedge clk);
            bus.i_lsu_addr = 32'h1000_0000 | (32'(i % 5) << 12);
            bus.i_lsu_wren = 1'b1;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wrap_pre got %h want ffff", cnt);
        end
        @(negedge clk);
        bus.i_lsu_addr = 32'h1000_4000;
        @(posedge clk);
        #1;
        bus.i_lsu_wren = 1'b0;
        n_checks++;
        if (cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL wrap_cnt got %h want 0000", cnt);
        end
        n_checks++;
        if (ledr !== 32'h0 || ledg !== 32'h0 || lcd !== 32'h0 ||
            {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0} !== 56'h0) begin
            n_fail++;
            $display("FAIL wrap_regs ledr=%h ledg=%h lcd=%h", ledr, ledg, lcd);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.i_lsu_addr = 32'h0;
        bus.i_st_data  = 32'h0;
        bus.i_lsu_wren = 1'b0;
        bus.i_bmask    = 4'h0;
        test_reset();
        test_ledr_word();
        test_byte_merge();
        test_hexhi();
        test_unmapped();
        test_same_cycle();
        test_zero_mask();
        test_reset_priority();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
